vga_fetch_arbiter: RTL and testbench

Shares the single-port synchronous data RAM between the CPU and the VGA bit-map display. It tracks `pixel_x`/`pixel_y` from the sync generator, fetches the framebuffer word under the beam, prefetches the next one, and drives `pixel_word` into the `vga` block's `pixel_in`. CPU reads and writes use the same RAM port under a fixed-priority scheduler, and the block keeps the VGA buffers coherent with CPU writes.

---
 rtl/vga_fetch_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_vga_fetch_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_arbiter.sv
// rtl/vga_fetch_arbiter.sv - single RAM port shared between the VGA framebuffer fetch and the CPU
module vga_fetch_arbiter #(
   parameter int DATA_WIDTH              = 16,
   parameter int ADDR_WIDTH              = 8,
   parameter int BITS_PER_MEMORY_PIXEL_X = 4,
   parameter int BITS_PER_MEMORY_PIXEL_Y = 4,
   parameter int WORDS_PER_ROW           = 2,
   parameter int ROWS                    = 24,
   parameter int FB_BASE                 = 0
) (
   input  logic                  CLK_50,
   input  logic                  RESET,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] pixel_word,
   output logic [7:0]            miss_count
);

   localparam int L = $clog2(DATA_WIDTH) + BITS_PER_MEMORY_PIXEL_X;
   localparam logic [9:0]            WPR_C    = 10'(WORDS_PER_ROW);
   localparam logic [9:0]            WLAST_C  = 10'(WORDS_PER_ROW - 1);
   localparam logic [9:0]            ROWS_C   = 10'(ROWS);
   localparam logic [10:0]           ROWS11_C = 11'(ROWS);
   localparam logic [ADDR_WIDTH-1:0] BASE_C   = ADDR_WIDTH'(FB_BASE);
   localparam logic [ADDR_WIDTH-1:0] WPRA_C   = ADDR_WIDTH'(WORDS_PER_ROW);

   typedef enum logic [1:0] {S_IDLE, S_RD_ISSUE, S_RD_DATA, S_WR} state_t;
   typedef enum logic [1:0] {SRC_VGA, SRC_CPU, SRC_PF} src_t;

   state_t                state_q, state_d;
   src_t                  src_q, src_d;
   logic [ADDR_WIDTH-1:0] tag_q, tag_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic [DATA_WIDTH-1:0] cur_word_q, cur_word_d, nxt_word_q, nxt_word_d;
   logic [ADDR_WIDTH-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
   logic                  cur_valid_q, cur_valid_d, nxt_valid_q, nxt_valid_d;
   logic [DATA_WIDTH-1:0] pixel_word_q, pixel_word_d;
   logic [7:0]            miss_q, miss_d;

   logic [9:0]            w_col, r_row;
   logic [10:0]           y_inc, r_nxt;
   logic                  active, hit, swap, vga_dem, pf_need;
   logic [ADDR_WIDTH-1:0] dem_addr, pf_addr;

   assign w_col    = pixel_x >> L;
   assign r_row    = pixel_y >> BITS_PER_MEMORY_PIXEL_Y;
   assign y_inc    = {1'b0, pixel_y} + 11'd1;
   assign r_nxt    = y_inc >> BITS_PER_MEMORY_PIXEL_Y;
   assign active   = (w_col < WPR_C) && (r_row < ROWS_C);
   assign dem_addr = BASE_C + ADDR_WIDTH'(r_row) * WPRA_C + ADDR_WIDTH'(w_col);

   // Prefetch target: next word on this row, else first word of the next memory row (wrapping to the top)
   always_comb begin
      pf_addr = BASE_C;
      if (active && (w_col < WLAST_C)) begin
         pf_addr = dem_addr + 1'b1;
      end else if (r_nxt < ROWS11_C) begin
         pf_addr = BASE_C + ADDR_WIDTH'(r_nxt) * WPRA_C;
      end
   end

   assign hit     = cur_valid_q && (cur_tag_q == dem_addr);
   assign swap    = active && !hit && nxt_valid_q && (nxt_tag_q == dem_addr);
   assign vga_dem = active && !hit && !swap;
   assign pf_need = !(nxt_valid_q && (nxt_tag_q == pf_addr)) && !(cur_valid_q && (cur_tag_q == pf_addr));

   // Scheduler, buffer management and display outputs
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      tag_d        = tag_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      cpu_ack_d    = 1'b0;
      cur_word_d   = cur_word_q;
      cur_tag_d    = cur_tag_q;
      cur_valid_d  = cur_valid_q;
      nxt_word_d   = nxt_word_q;
      nxt_tag_d    = nxt_tag_q;
      nxt_valid_d  = nxt_valid_q;
      pixel_word_d = (active && hit) ? cur_word_q : '0;
      miss_d       = (vga_dem && (miss_q != 8'hFF)) ? miss_q + 8'd1 : miss_q;

      if (swap) begin
         cur_word_d  = nxt_word_q;
         cur_tag_d   = nxt_tag_q;
         cur_valid_d = 1'b1;
         nxt_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (vga_dem) begin
               src_d      = SRC_VGA;
               tag_d      = dem_addr;
               mem_addr_d = dem_addr;
               state_d    = S_RD_ISSUE;
            end else if (cpu_req && !cpu_ack_q) begin
               // cpu_req is ignored while ack is showing so a held request is not issued twice
               src_d      = SRC_CPU;
               tag_d      = cpu_addr;
               mem_addr_d = cpu_addr;
               if (cpu_we) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = cpu_wdata;
                  state_d     = S_WR;
               end else begin
                  state_d = S_RD_ISSUE;
               end
            end else if (pf_need) begin
               src_d      = SRC_PF;
               tag_d      = pf_addr;
               mem_addr_d = pf_addr;
               state_d    = S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: state_d = S_RD_DATA;
         S_RD_DATA: begin
            state_d = S_IDLE;
            case (src_q)
               SRC_VGA: begin
                  cur_word_d  = mem_rdata;
                  cur_tag_d   = tag_q;
                  cur_valid_d = 1'b1;
               end
               SRC_PF: begin
                  nxt_word_d  = mem_rdata;
                  nxt_tag_d   = tag_q;
                  nxt_valid_d = 1'b1;
               end
               default: begin
                  cpu_rdata_d = mem_rdata;
                  cpu_ack_d   = 1'b1;
               end
            endcase
         end
         S_WR: begin
            // Checked after any swap this cycle so a word moved into cur is still caught
            state_d   = S_IDLE;
            cpu_ack_d = 1'b1;
            if (cur_tag_d == mem_addr_q) cur_valid_d = 1'b0;
            if (nxt_tag_d == mem_addr_q) nxt_valid_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset aborts any transaction in flight without an ack
   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         src_q        <= SRC_VGA;
         tag_q        <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         cur_word_q   <= '0;
         cur_tag_q    <= '0;
         cur_valid_q  <= 1'b0;
         nxt_word_q   <= '0;
         nxt_tag_q    <= '0;
         nxt_valid_q  <= 1'b0;
         pixel_word_q <= '0;
         miss_q       <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         tag_q        <= tag_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_ack_q    <= cpu_ack_d;
         cur_word_q   <= cur_word_d;
         cur_tag_q    <= cur_tag_d;
         cur_valid_q  <= cur_valid_d;
         nxt_word_q   <= nxt_word_d;
         nxt_tag_q    <= nxt_tag_d;
         nxt_valid_q  <= nxt_valid_d;
         pixel_word_q <= pixel_word_d;
         miss_q       <= miss_d;
      end
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_ack    = cpu_ack_q;
   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;
   assign pixel_word = pixel_word_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// tb/tb_vga_fetch_arbiter.sv - directed and randomized checks of vga_fetch_arbiter against a framebuffer model
module tb_vga_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  px, py;
   logic        cpu_req, cpu_we;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        cpu_ack;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic [15:0] pixel_word;
   logic [7:0]  miss_count;

   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [15:0] ld_data;
   logic [15:0] ram [256];
   logic [15:0] model_mem [256];
   int          we_cnt = 0;

   int vectors = 0;
   int miscompares = 0;

   vga_fetch_arbiter dut (
      .CLK_50(clk), .RESET(rst), .pixel_x(px), .pixel_y(py),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pixel_word(pixel_word), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM with a preload port
   always @(posedge clk) begin
      if (ld_en) ram[ld_addr] <= ld_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
      if (mem_we) we_cnt <= we_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Framebuffer word index under the beam, -1 outside the bitmap
   function automatic int fb_index(input int x, input int y);
      int w;
      int r;
      w = x / 256;
      r = y / 16;
      if (w < 2 && r < 24) return r * 2 + w;
      return -1;
   endfunction

   function automatic logic [31:0] exp_pixel(input int x, input int y);
      int idx;
      idx = fb_index(x, y);
      if (idx < 0) return 32'h0;
      return 32'(model_mem[idx]);
   endfunction

   task automatic cpu_op(input logic we, input logic [7:0] addr, input logic [15:0] data,
                         output logic [15:0] rd, output int lat);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
      lat = 0; rd = 16'h0;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (cpu_ack) begin
            lat = n;
            rd  = cpu_rdata;
            break;
         end
      end
      cpu_req = 1'b0;
      if (lat == 0) chk("ack_timeout", 32'(cpu_ack), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pixel_word"}, 32'(pixel_word), 32'h0);
      chk({tag, "_miss_count"}, 32'(miss_count), 32'h0);
      chk({tag, "_cpu_ack"},    32'(cpu_ack),    32'h0);
      chk({tag, "_cpu_rdata"},  32'(cpu_rdata),  32'h0);
      chk({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
      chk({tag, "_mem_we"},     32'(mem_we),     32'h0);
      chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'h0);
   endtask

   initial begin
      logic [15:0] rd;
      int          lat;
      int          we0;
      int          exp_miss;
      int          x, y, op;
      logic [7:0]  a;
      logic [15:0] d;

      rst = 1'b1; px = 10'd0; py = 10'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 16'h0;
      ld_en = 1'b0; ld_addr = 8'h0; ld_data = 16'h0;

      for (int i = 0; i < 256; i++) model_mem[i] = 16'($urandom);
      model_mem[0]     = 16'hA5A5;
      model_mem[1]     = 16'h1234;
      model_mem[8'h40] = 16'hBEEF;
      ld_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ld_addr = 8'(i);
         ld_data = model_mem[i];
         tick();
      end
      ld_en = 1'b0;

      // Reset values
      chk_all_zero("reset");

      // Cold miss at (0,0): three miss cycles, then the word
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("cold_pixel_zero", 32'(pixel_word), 32'h0);
         chk("cold_miss", 32'(miss_count), 32'(i));
      end
      tick();
      chk("cold_pixel", 32'(pixel_word), 32'hA5A5);
      chk("cold_miss_final", 32'(miss_count), 32'd3);
      chk("prefetch_addr", 32'(mem_addr), 32'd1);
      exp_miss = 3;

      // Word boundary 255 -> 256 served by a swap
      px = 10'd255;
      repeat (4) tick();
      chk("x255_pixel", 32'(pixel_word), 32'hA5A5);
      px = 10'd256;
      tick(); tick();
      chk("swap_pixel", 32'(pixel_word), 32'h1234);
      chk("swap_miss", 32'(miss_count), 32'(exp_miss));

      // CPU read outside the active area
      px = 10'd600;
      repeat (6) tick();
      chk("blank_pixel", 32'(pixel_word), 32'h0);
      we0 = we_cnt;
      cpu_op(1'b0, 8'h40, 16'h0, rd, lat);
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_data", 32'(rd), 32'hBEEF);
      chk("rd_no_we", 32'(we_cnt - we0), 32'd0);
      tick();
      chk("ack_one_cycle", 32'(cpu_ack), 32'd0);

      // CPU write to the word under the beam
      px = 10'd0;
      repeat (6) tick();
      chk("w0_pixel", 32'(pixel_word), 32'hA5A5);
      chk("w0_miss", 32'(miss_count), 32'(exp_miss));
      we0 = we_cnt;
      cpu_op(1'b1, 8'h00, 16'h0F0F, rd, lat);
      model_mem[0] = 16'h0F0F;
      chk("wr_latency", 32'(lat), 32'd2);
      chk("wr_one_we", 32'(we_cnt - we0), 32'd1);
      repeat (6) tick();
      exp_miss += 3;
      chk("coherent_pixel", 32'(pixel_word), 32'h0F0F);
      chk("coherent_miss", 32'(miss_count), 32'(exp_miss));

      // CPU read arriving together with a VGA miss
      py = 10'd32;
      cpu_op(1'b0, 8'h03, 16'h0, rd, lat);
      chk("contend_latency", 32'(lat), 32'd6);
      chk("contend_data", 32'(rd), 32'(model_mem[3]));
      repeat (6) tick();
      exp_miss += 3;
      chk("contend_pixel", 32'(pixel_word), 32'(model_mem[4]));
      chk("contend_miss", 32'(miss_count), 32'(exp_miss));

      // Bottom line prefetches the top of the framebuffer
      px = 10'd512; py = 10'd383;
      repeat (6) tick();
      chk("bottom_pixel", 32'(pixel_word), 32'h0);
      px = 10'd0; py = 10'd0;
      tick(); tick();
      chk("wrap_pixel", 32'(pixel_word), 32'h0F0F);
      chk("wrap_miss", 32'(miss_count), 32'(exp_miss));

      // Reset during the data cycle of a CPU read
      repeat (6) tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
      tick(); tick();
      rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      cpu_req = 1'b0;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("midreset_no_ack", 32'(cpu_ack), 32'd0);
      end

      // Randomized beam positions and CPU traffic against the framebuffer model
      for (int it = 0; it < 30; it++) begin
         x  = int'($urandom_range(0, 639));
         y  = int'($urandom_range(0, 479));
         op = int'($urandom_range(0, 2));
         a  = 8'($urandom_range(0, 63));
         d  = 16'($urandom);
         px = 10'(x); py = 10'(y);
         if (op == 1) begin
            cpu_op(1'b1, a, d, rd, lat);
            model_mem[a] = d;
         end else if (op == 2) begin
            cpu_op(1'b0, a, 16'h0, rd, lat);
            chk("rand_rd_data", 32'(rd), 32'(model_mem[a]));
         end
         repeat (12) tick();
         chk("rand_pixel", 32'(pixel_word), exp_pixel(x, y));
         chk("rand_idle_we", 32'(mem_we), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
